pll_step_sequencer: RTL
=======================

// Module: pll_step_sequencer
// PURPOSE
//  Sequences one PLL control step per clk_control rising edge:
//  alphaBeta -> ab_dq -> PI -> VCO, one stage at a time, over start/done handshakes.
//  Guards each stage with a timeout watchdog and counts control ticks that arrive while a step is still running (overruns).
//  Qualifies PLL lock from the q-axis error.
//  Sits between the control-rate tick and the stage valid/ready logic inside pll.
// PARAMETERS
//  DATA_WIDTH      32        width of q_in, signed, Q(DATA_WIDTH-FP_WIDTH).FP_WIDTH
//  FP_WIDTH        24        fractional bits of q_in
//  N_STAGES        4         number of sequenced stages; index 0 runs first
//  TIMEOUT_CYCLES  1000      max Clk cycles a stage may take, counted from its start pulse
//  LOCK_THR        1677722   |q| threshold for lock (0.1 in Q8.24)
//  LOCK_COUNT      50        consecutive in-threshold steps required to declare lock
//  CNT_WIDTH       16        width of overrun_cnt and timeout counter
// PORTS
//  Clk          in   1           system clock
//  Resetn       in   1           asynchronous, active-low reset
//  clk_control  in   1           control-rate tick source, asynchronous to Clk
//  enable       in   1           0: ticks ignored; the step in flight still completes
//  clear_err    in   1           1-cycle pulse: clears timeout_err and overrun_cnt
//  stage_done   in   N_STAGES    done/valid from each stage; only the active index is honoured
//  q_in         in   DATA_WIDTH  q-axis error from ab_dq, sampled in DONE
//  stage_start  out  N_STAGES    one-hot, 1-cycle start pulse to the active stage
//  busy         out  1           1 whenever state != IDLE
//  step_done    out  1           1-cycle pulse when all stages complete
//  active_stage out  clog2(N)    index of the stage running or awaited
//  timeout_err  out  1           sticky; set on any stage timeout
//  overrun_cnt  out  CNT_WIDTH   saturating count of dropped ticks
//  locked       out  1           PLL lock flag
// BEHAVIOUR
//  Reset values:
//   - All outputs 0; state IDLE; lock counter 0.
//   - Sync flops and timeout counter 0.
//  Tick generation:
//   - clk_control passes through a 2-FF synchroniser, then a rising-edge detector.
//   - tick is a 1-cycle pulse, 3 Clk cycles after the edge.
//  State machine:
//   - IDLE: on tick && enable -> ISSUE with active_stage = 0.
//   - ISSUE: stage_start[active_stage] = 1 for this cycle only; timeout counter loaded with 0; -> WAIT.
//   - WAIT: timeout counter increments every cycle.
//     - stage_done[active_stage] seen (in ISSUE or WAIT) and active_stage < N-1 -> ISSUE with the next stage.
//     - stage_done[active_stage] seen and this is the last stage -> DONE.
//     - Counter reaches TIMEOUT_CYCLES-1 with no done -> set timeout_err, clear the lock state, -> IDLE. No step_done is issued.
//   - DONE: step_done = 1 for one cycle; lock update; -> IDLE.
//  Handshake rules:
//   - A done seen in the ISSUE cycle counts; a stage may complete in the same cycle it is started.
//   - Done on a non-active index is ignored.
//   - When done and timeout occur in the same cycle, done wins.
//  Overruns:
//   - A tick while state != IDLE (DONE included) is dropped.
//   - overrun_cnt then increments, saturating at 2^CNT_WIDTH-1.
//   - If clear_err and an overrun occur in the same cycle, the result is overrun_cnt = 1.
//  Lock update (DONE only):
//   - abs(q_in) is computed with saturation: the most-negative value maps to max positive.
//   - abs(q_in) <= LOCK_THR: lock counter++, saturating at LOCK_COUNT; locked = 1 when the counter reaches LOCK_COUNT.
//   - Otherwise: lock counter = 0 and locked = 0.
//  Latency:
//   - tick to stage_start[0] is 1 cycle.
//   - last done to step_done is 1 cycle.
//  Other conditions:
//   - enable = 0 in IDLE: ticks are dropped and not counted as overruns.
//   - Resetn asserted mid-step: immediate return to reset values; the stage in flight is abandoned.
// STRUCTURE
//  - Shared include pll_pkg.vh holds: state encoding (IDLE/ISSUE/WAIT/DONE), stage index constants (STG_AB, STG_DQ, STG_PI, STG_VCO), Q8.24 helper constants.
//  - One sub-module, pll_tick_sync: 2-FF synchroniser plus rising-edge pulse, reusable by pid/vco.
// TESTING
//  1. clk_control edge, each stage_done returns 2 cycles after its start -> starts at +4,+7,+10,+13 after the edge; step_done at +16.
//  2. Stage 2 never returns, TIMEOUT_CYCLES = 8 -> timeout_err = 1, no step_done, FSM back in IDLE, next tick restarts at stage 0.
//  3. Two ticks inside one step, then clear_err -> overrun_cnt = 2, then 0; step completes normally.
//  4. q_in = 0x00100000 (<= LOCK_THR) for 50 steps -> locked rises after step 50; one step with q_in = 0x01000000 -> locked = 0.
//  5. q_in = 0x80000000 in DONE -> treated as out of threshold; lock counter cleared.
//  6. Resetn low while in WAIT on stage 1 -> all outputs 0 asynchronously; after release, the first tick starts stage 0.

Source files
------------

// File: rtl/pll_pkg.sv
// rtl/pll_pkg.sv - shared state encoding, stage indices and Q8.24 constants for the PLL sequencer
package pll_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } pll_state_e;

    typedef enum logic [1:0] {
        STG_AB  = 2'd0,
        STG_DQ  = 2'd1,
        STG_PI  = 2'd2,
        STG_VCO = 2'd3
    } pll_stage_e;

    localparam int N_STG       = int'(STG_VCO) + 1;
    localparam int Q_FRAC_BITS = 24;
    // 0.1 in Q8.24
    localparam int Q_TENTH     = 1677722;

endpackage

// File: rtl/pll_tick_sync.sv
// rtl/pll_tick_sync.sv - 2-FF synchroniser plus registered rising-edge pulse
module pll_tick_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic tick
);

    // [0],[1] are the synchroniser pair, [2] holds the previous synchronised level
    logic [2:0] sync_q, sync_d;
    logic       tick_q, tick_d;

    // shift the asynchronous level in and detect a low-to-high transition
    always_comb begin
        sync_d = {sync_q[1:0], async_in};
        tick_d = sync_q[1] & ~sync_q[2];
    end

    // synchroniser and pulse registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            tick_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/pll_step_sequencer.sv
// rtl/pll_step_sequencer.sv - sequences one PLL control step through its stages with watchdog, overrun count and lock
module pll_step_sequencer import pll_pkg::*; #(
    parameter int DATA_WIDTH     = 32,
    parameter int FP_WIDTH       = Q_FRAC_BITS,
    parameter int N_STAGES       = N_STG,
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int LOCK_THR       = Q_TENTH,
    parameter int LOCK_COUNT     = 50,
    parameter int CNT_WIDTH      = 16,
    localparam int AW            = (N_STAGES > 1) ? $clog2(N_STAGES) : 1
) (
    input  logic                  Clk,
    input  logic                  Resetn,
    input  logic                  clk_control,
    input  logic                  enable,
    input  logic                  clear_err,
    input  logic [N_STAGES-1:0]   stage_done,
    input  logic [DATA_WIDTH-1:0] q_in,
    output logic [N_STAGES-1:0]   stage_start,
    output logic                  busy,
    output logic                  step_done,
    output logic [AW-1:0]         active_stage,
    output logic                  timeout_err,
    output logic [CNT_WIDTH-1:0]  overrun_cnt,
    output logic                  locked
);

    localparam int LW = $clog2(LOCK_COUNT + 1);

    if (FP_WIDTH >= DATA_WIDTH) begin : g_fp_check
        $error("FP_WIDTH must leave at least one integer bit");
    end

    pll_state_e            state_q, state_d;
    logic [AW-1:0]         stage_q, stage_d;
    logic [CNT_WIDTH-1:0]  tmo_q, tmo_d;
    logic [CNT_WIDTH-1:0]  ovr_q, ovr_d;
    logic                  terr_q, terr_d;
    logic [LW-1:0]         lock_cnt_q, lock_cnt_d;
    logic                  locked_q, locked_d;

    logic                  tick;
    logic                  done_act;
    logic                  last_stage;
    logic                  overrun;
    logic                  in_thr;
    logic [DATA_WIDTH-1:0] q_abs;

    pll_tick_sync u_tick_sync (
        .clk      (Clk),
        .rst_n    (Resetn),
        .async_in (clk_control),
        .tick     (tick)
    );

    assign done_act   = stage_done[stage_q];
    assign last_stage = (stage_q == AW'(N_STAGES - 1));
    assign overrun    = tick && (state_q != ST_IDLE);

    // saturating magnitude of q so the most-negative code cannot wrap to itself
    always_comb begin
        q_abs = q_in;
        if (q_in[DATA_WIDTH-1]) begin
            if (q_in == {1'b1, {(DATA_WIDTH-1){1'b0}}}) begin
                q_abs = {1'b0, {(DATA_WIDTH-1){1'b1}}};
            end else begin
                q_abs = ~q_in + DATA_WIDTH'(1);
            end
        end
        in_thr = (q_abs <= DATA_WIDTH'(LOCK_THR));
    end

    // step FSM: stage issue/wait, watchdog, lock qualification; a timeout set beats clear_err
    always_comb begin
        state_d     = state_q;
        stage_d     = stage_q;
        tmo_d       = tmo_q;
        terr_d      = terr_q;
        lock_cnt_d  = lock_cnt_q;
        locked_d    = locked_q;
        stage_start = '0;
        step_done   = 1'b0;

        if (clear_err) begin
            terr_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (tick && enable) begin
                    state_d = ST_ISSUE;
                    stage_d = AW'(STG_AB);
                end
            end
            ST_ISSUE: begin
                stage_start = N_STAGES'(1) << stage_q;
                tmo_d       = '0;
                if (done_act) begin
                    if (last_stage) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_ISSUE;
                        stage_d = stage_q + AW'(1);
                    end
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                tmo_d = tmo_q + CNT_WIDTH'(1);
                if (done_act) begin
                    if (last_stage) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_ISSUE;
                        stage_d = stage_q + AW'(1);
                    end
                end else if (tmo_q == CNT_WIDTH'(TIMEOUT_CYCLES - 1)) begin
                    terr_d     = 1'b1;
                    lock_cnt_d = '0;
                    locked_d   = 1'b0;
                    state_d    = ST_IDLE;
                end
            end
            ST_DONE: begin
                step_done = 1'b1;
                state_d   = ST_IDLE;
                if (in_thr) begin
                    if (lock_cnt_q != LW'(LOCK_COUNT)) begin
                        lock_cnt_d = lock_cnt_q + LW'(1);
                    end
                    locked_d = (lock_cnt_d == LW'(LOCK_COUNT));
                end else begin
                    lock_cnt_d = '0;
                    locked_d   = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // dropped-tick counter; an overrun coinciding with clear_err leaves a count of one
    always_comb begin
        ovr_d = ovr_q;
        if (clear_err) begin
            ovr_d = overrun ? CNT_WIDTH'(1) : '0;
        end else if (overrun && (ovr_q != '1)) begin
            ovr_d = ovr_q + CNT_WIDTH'(1);
        end
    end

    // state and status registers
    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) begin
            state_q    <= ST_IDLE;
            stage_q    <= '0;
            tmo_q      <= '0;
            ovr_q      <= '0;
            terr_q     <= 1'b0;
            lock_cnt_q <= '0;
            locked_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            stage_q    <= stage_d;
            tmo_q      <= tmo_d;
            ovr_q      <= ovr_d;
            terr_q     <= terr_d;
            lock_cnt_q <= lock_cnt_d;
            locked_q   <= locked_d;
        end
    end

    assign busy         = (state_q != ST_IDLE);
    assign active_stage = stage_q;
    assign timeout_err  = terr_q;
    assign overrun_cnt  = ovr_q;
    assign locked       = locked_q;

endmodule
